// File: rtl/global_avgpool_engine_if.sv
`default_nettype none
// ============================================================================
// global_avgpool_engine_if
//   Command, SRAM0 port and status bundle for the global average pooling engine.
//   Revision: 1.0
// ============================================================================
interface global_avgpool_engine_if #(
  parameter int SRAM0_AW = 16
);
  logic                cmd_valid;
  logic [15:0]         cmd_src_base;
  logic [15:0]         cmd_dst_base;
  logic [15:0]         cmd_C;
  logic [15:0]         cmd_H;
  logic [15:0]         cmd_W;

  logic                sram_rd_en;
  logic [SRAM0_AW-1:0] sram_rd_addr;
  logic [7:0]          sram_rd_data;
  logic                sram_wr_en;
  logic [SRAM0_AW-1:0] sram_wr_addr;
  logic [7:0]          sram_wr_data;

  logic                busy;
  logic                done;

  // Host / memory side
  modport master (
    output cmd_valid, cmd_src_base, cmd_dst_base, cmd_C, cmd_H, cmd_W,
    output sram_rd_data,
    input  sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data,
    input  busy, done
  );

  // Engine side
  modport slave (
    input  cmd_valid, cmd_src_base, cmd_dst_base, cmd_C, cmd_H, cmd_W,
    input  sram_rd_data,
    output sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data,
    output busy, done
  );
endinterface
`default_nettype wire

// File: rtl/global_avgpool_engine.sv
`default_nettype none
// ============================================================================
// global_avgpool_engine
//   Reduces each INT8 channel plane of a [C,H,W] map in SRAM0 to a rounded mean.
//   Revision: 1.0
// ============================================================================
module global_avgpool_engine #(
  parameter int SRAM0_AW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  global_avgpool_engine_if.slave bus
);

  typedef enum logic [2:0] {
    GA_IDLE  = 3'd0,
    GA_READ  = 3'd1,
    GA_DRAIN = 3'd2,
    GA_DIV   = 3'd3,
    GA_WRITE = 3'd4,
    GA_DONE  = 3'd5
  } state_t;

  state_t state, state_nx;

  logic [15:0]         c_total;
  logic [15:0]         count;
  logic [15:0]         idx;
  logic [15:0]         ch;
  logic [4:0]          step;
  logic [SRAM0_AW-1:0] dst_base;
  logic [SRAM0_AW-1:0] rd_ptr;
  logic [23:0]         acc;
  logic                vld;
  logic [23:0]         quo;
  logic [16:0]         rem;

  logic                rd_en;
  logic [SRAM0_AW-1:0] rd_addr;
  logic                wr_en;
  logic [SRAM0_AW-1:0] wr_addr;
  logic [7:0]          wr_data;

  logic                cmd_zero;
  logic [15:0]         cmd_count;
  logic                last_idx;
  logic                last_ch;
  logic [23:0]         acc_mag;
  logic [23:0]         dvd;
  logic [16:0]         rem_sh;
  logic [16:0]         rem_sub;
  logic                fits;
  logic                round_up;
  logic [24:0]         q_rnd;
  logic [7:0]          result;

  assign cmd_zero  = (bus.cmd_C == 16'd0) || (bus.cmd_H == 16'd0) || (bus.cmd_W == 16'd0);
  assign cmd_count = bus.cmd_H * bus.cmd_W;
  assign last_idx  = (idx == count - 16'd1);
  assign last_ch   = ((ch + 16'd1) == c_total);

  // Restoring division: the dividend is taken straight from |acc| on the first step
  assign acc_mag = acc[23] ? (~acc + 24'd1) : acc;
  assign dvd     = (step == 5'd0) ? acc_mag : quo;
  assign rem_sh  = {((step == 5'd0) ? 16'd0 : rem[15:0]), dvd[23]};
  assign fits    = (rem_sh >= {1'b0, count});
  assign rem_sub = rem_sh - {1'b0, count};

  assign round_up = ({rem, 1'b0} >= {2'b00, count});
  assign q_rnd    = {1'b0, quo} + {24'd0, round_up};

  always_comb begin
    result = q_rnd[7:0];
    if (acc[23]) begin
      if (q_rnd > 25'd128) result = 8'h80;
      else                 result = ~q_rnd[7:0] + 8'd1;
    end else if (q_rnd > 25'd127) begin
      result = 8'h7F;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= GA_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      GA_IDLE:  if (bus.cmd_valid) state_nx = cmd_zero ? GA_DONE : GA_READ;
      GA_READ:  if (last_idx) state_nx = GA_DRAIN;
      GA_DRAIN: if (step == 5'd1) state_nx = GA_DIV;
      GA_DIV:   if (step == 5'd23) state_nx = GA_WRITE;
      GA_WRITE: state_nx = last_ch ? GA_DONE : GA_READ;
      GA_DONE:  state_nx = GA_IDLE;
      default:  state_nx = GA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_total  <= '0;
      count    <= '0;
      idx      <= '0;
      ch       <= '0;
      step     <= '0;
      dst_base <= '0;
      rd_ptr   <= '0;
      acc      <= '0;
      vld      <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      rd_en <= 1'b0;
      wr_en <= 1'b0;
      vld   <= rd_en;
      if (vld) acc <= acc + {{16{bus.sram_rd_data[7]}}, bus.sram_rd_data};

      case (state)
        GA_IDLE: begin
          if (bus.cmd_valid) begin
            c_total  <= bus.cmd_C;
            count    <= cmd_count;
            dst_base <= SRAM0_AW'(bus.cmd_dst_base);
            rd_ptr   <= SRAM0_AW'(bus.cmd_src_base);
            acc      <= '0;
            ch       <= '0;
            idx      <= '0;
            step     <= '0;
          end
        end
        // Planes are contiguous, so one running pointer covers src_base + c*count + idx
        GA_READ: begin
          rd_en   <= 1'b1;
          rd_addr <= rd_ptr;
          rd_ptr  <= rd_ptr + SRAM0_AW'(1);
          idx     <= last_idx ? 16'd0 : idx + 16'd1;
          step    <= '0;
        end
        GA_DRAIN: begin
          step <= (step == 5'd1) ? 5'd0 : step + 5'd1;
        end
        GA_DIV: begin
          quo  <= {dvd[22:0], fits};
          rem  <= fits ? rem_sub : rem_sh;
          step <= (step == 5'd23) ? 5'd0 : step + 5'd1;
        end
        GA_WRITE: begin
          wr_en   <= 1'b1;
          wr_addr <= dst_base + SRAM0_AW'(ch);
          wr_data <= result;
          acc     <= '0;
          ch      <= ch + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.sram_rd_en   = rd_en;
  assign bus.sram_rd_addr = rd_addr;
  assign bus.sram_wr_en   = wr_en;
  assign bus.sram_wr_addr = wr_addr;
  assign bus.sram_wr_data = wr_data;
  assign bus.busy         = (state != GA_IDLE);
  assign bus.done         = (state == GA_DONE);

endmodule
`default_nettype wire

// File: doc/global_avgpool_engine.md
# global_avgpool_engine

Global average pooling engine for the graph datapath. Sits directly downstream of the 2D max-pool stage. It reads an INT8 NCHW feature map [1,C,H,W] from SRAM0 and reduces each channel plane to one rounded INT8 mean. It writes the C-element vector back to SRAM0 for the following fully-connected stage.

## Interface
- SRAM0_AW, 16, SRAM0 address width; all computed addresses wrap modulo 2^SRAM0_AW
- clk  in  1  clock; reset rst_n, asynchronous, active-low
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  start pulse; sampled only in GA_IDLE
- cmd_src_base  in  16  SRAM base of input [C,H,W]
- cmd_dst_base  in  16  SRAM base of output [C]
- cmd_C  in  16  channel count
- cmd_H  in  16  plane height
- cmd_W  in  16  plane width
- sram_rd_en  out  1  read strobe (registered)
- sram_rd_addr  out  SRAM0_AW  read address (registered)
- sram_rd_data  in  8  read data, valid the cycle after sram_rd_en is high
- sram_wr_en  out  1  write strobe (registered)
- sram_wr_addr  out  SRAM0_AW  write address (registered)
- sram_wr_data  out  8  write data (registered)
- busy  out  1  state != GA_IDLE
- done  out  1  one-cycle pulse in GA_DONE

## Operation
- Reset: state GA_IDLE; sram_rd_en, sram_wr_en, busy, done = 0; sram_rd_addr, sram_wr_addr, sram_wr_data = 0; accumulator and counters = 0.
- GA_IDLE: on cmd_valid, latch all cmd fields and compute count = H*W (16-bit; H*W must be ≤ 65535). If C, H or W is 0, go to GA_DONE with no SRAM traffic. Otherwise clear acc and c, and go to GA_READ.
- GA_READ: one read per cycle for idx = 0..count-1, with addr = src_base + c*count + idx. Leave after issuing idx = count-1.
- Accumulate: acc (signed 24-bit) += sign-extended sram_rd_data in every cycle whose previous cycle had sram_rd_en = 1. A 1-bit valid pipe tracks this.
- GA_DRAIN: 2 cycles, letting the last issued read land and be accumulated.
- GA_DIV: 24-cycle restoring division of |acc| by count, with a 24-bit quotient and a 17-bit partial remainder.
  - Rounding: if 2*rem ≥ count, then q += 1 (round half away from zero).
  - Sign: apply the sign of acc.
  - Saturation: clamp to [-128, 127]. A mean of INT8 data always fits; the clamp is defensive.
- GA_WRITE: wr_en=1, wr_addr = dst_base + c, wr_data = result. Then clear acc.
  - If c+1 == C, go to GA_DONE.
  - Otherwise c += 1 and go to GA_READ.
- GA_DONE: done=1 for one cycle, then GA_IDLE.
- cmd_valid while busy is ignored; command inputs need only be stable in the accept cycle.
- Reset mid-operation: return immediately to reset values. No partial write or done pulse is emitted afterwards.

## Timing
- Accept at cycle T; first GA_READ cycle is T+1; sram_rd_en is first high at T+2.
- Per-channel duration: count (READ) + 2 (DRAIN) + 24 (DIV) + 1 (WRITE) = count+27 cycles.
- done is high in cycle T+1+C*(count+27); busy is high from T+1 through that cycle inclusive.
- Write for channel c: sram_wr_en is high for exactly one cycle, the cycle after that channel's GA_WRITE state.
- Read strobes are back-to-back, with no bubbles within a channel.
- Degenerate command (C, H or W = 0): done at T+1; no rd_en or wr_en ever asserted.

## Test plan
- C=1,H=W=2, src={1,2,3,4} -> one write of 3 (10/4 = 2.5 rounds up) to dst_base; done at T+1+31.
- C=1,H=W=2, src={-1,-2,-3,-4} -> writes 0xFD (-3, half away from zero); {-1,-1,-1,0} -> writes 0xFF (-0.75 -> -1).
- C=3,H=W=3, planes all 127, all -128, and ramp -4..4 -> writes 127, -128, 0 at dst+0..2.
  - Check rd_en runs 9 consecutive cycles per channel.
  - Check done at T+1+3*36.
- cmd_C=0, and separately cmd_W=0 -> done pulse at T+1; zero reads and writes; busy high one cycle.
- cmd_valid re-asserted mid-run with different fields -> ignored; outputs match the first command. Then assert rst_n=0 mid-GA_DIV -> all outputs 0 immediately, no later write. A fresh command afterwards completes correctly.
- src_base = 2^SRAM0_AW-2, C=1,H=1,W=4 -> read addresses wrap to 0 and 1; result equals the mean of those 4 bytes.
